// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Summary  : Shifts a word one bit per clock (pass/LSL/LSR/ASR) and returns
//            the result through a start/busy/done handshake. Each shifting
//            cycle also reports the shift code it applies, for trace/debug.
//            Optional macro SHIFT_SEQ_ROTATE_EN adds a 'rotate' input that
//            turns op 10 into a rotate right.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] sout,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic [1:0]       shift_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_step_sout;
  logic             w_step_carry;
  logic             w_fill_msb;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic r_rot;
  // Rotate only feeds the LSR fill bit; other codes never look at it.
  assign w_fill_msb = r_rot & sout[0];
`else
  assign w_fill_msb = 1'b0;
`endif

  always_comb begin
    w_step_sout  = sout;
    w_step_carry = carry;
    case (r_op)
      2'b01: begin
        w_step_carry = sout[WIDTH-1];
        w_step_sout  = {sout[WIDTH-2:0], 1'b0};
      end
      2'b10: begin
        w_step_carry = sout[0];
        w_step_sout  = {w_fill_msb, sout[WIDTH-1:1]};
      end
      2'b11: begin
        w_step_carry = sout[0];
        w_step_sout  = {sout[WIDTH-1], sout[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_op       <= 2'b00;
      r_cnt      <= '0;
      sout       <= '0;
      carry      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_code <= 2'b00;
`ifdef SHIFT_SEQ_ROTATE_EN
      r_rot      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            sout  <= in;
            carry <= 1'b0;
            r_op  <= op;
            r_cnt <= amount;
`ifdef SHIFT_SEQ_ROTATE_EN
            r_rot <= rotate;
`endif
            if (op == 2'b00 || amount == '0) begin
              r_state    <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              shift_code <= 2'b00;
            end else begin
              r_state    <= SHIFT;
              busy       <= 1'b1;
              done       <= 1'b0;
              shift_code <= op;
            end
          end else begin
            r_state    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_code <= 2'b00;
          end
        end
        SHIFT: begin
          sout  <= w_step_sout;
          carry <= w_step_carry;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == AMT_W'(1)) begin
            r_state    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            shift_code <= 2'b00;
          end
        end
        default: begin
          r_state    <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          shift_code <= 2'b00;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; expected values hand-computed.
`default_nettype none

module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in = '0;
  logic [1:0]  op = '0;
  logic [3:0]  amount = '0;
  logic        rotate = 1'b0;
  logic [15:0] sout;
  logic        carry;
  logic        busy;
  logic        done;
  logic [1:0]  shift_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .in         (in),
    .op         (op),
    .amount     (amount),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rotate     (rotate),
`endif
    .sout       (sout),
    .carry      (carry),
    .busy       (busy),
    .done       (done),
    .shift_code (shift_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launches one operation at a negedge and checks every cycle up to done.
  // glitch: re-pulse start with other operands while busy (must be ignored).
  // b2b: issue 0x0001 LSL 1 in the done cycle and check it follows directly.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                        input logic [3:0] amt, input logic rot,
                        input logic [15:0] es, input logic ec,
                        input bit glitch, input bit b2b);
    int lat;
    lat = (o == 2'b00 || amt == 4'd0) ? 1 : int'(amt) + 1;
    @(negedge clk);
    in = a; op = o; amount = amt; rotate = rot; start = 1'b1;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0; in = ~a; op = ~o; amount = ~amt; rotate = ~rot;
      end
      if (glitch && cyc == 2) begin
        start = 1'b1; in = 16'hAAAA; op = 2'b10; amount = 4'd1;
      end
      if (glitch && cyc == 3) start = 1'b0;
      if (cyc < lat) begin
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        check({tag, " code"}, {30'd0, shift_code}, {30'd0, o});
        check({tag, " early done"}, {31'd0, done}, 32'd0);
      end else begin
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        check({tag, " code@done"}, {30'd0, shift_code}, 32'd0);
        check({tag, " sout"}, {16'd0, sout}, {16'd0, es});
        check({tag, " carry"}, {31'd0, carry}, {31'd0, ec});
      end
    end
    if (b2b) begin
      in = 16'h0001; op = 2'b01; amount = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " b2b busy"}, {31'd0, busy}, 32'd1);
      check({tag, " b2b code"}, {30'd0, shift_code}, 32'd1);
      @(negedge clk);
      check({tag, " b2b done"}, {31'd0, done}, 32'd1);
      check({tag, " b2b sout"}, {16'd0, sout}, 32'h0002);
      check({tag, " b2b carry"}, {31'd0, carry}, 32'd0);
    end
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int seen_done;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst sout", {16'd0, sout}, 32'd0);
    check("rst flags", {28'd0, carry, busy, done, 1'b0}, 32'd0);
    check("rst code", {30'd0, shift_code}, 32'd0);
    reset_n = 1'b1;

    // Asynchronous abort mid-SHIFT
    @(negedge clk);
    in = 16'h8001; op = 2'b01; amount = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort sout", {16'd0, sout}, 32'd0);
    check("abort carry", {31'd0, carry}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort code", {30'd0, shift_code}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort no done", seen_done, 0);

    run_op("lsl",    16'h0F0F, 2'b01, 4'd4,  1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b0);
    run_op("asr",    16'h8004, 2'b11, 4'd3,  1'b0, 16'hF000, 1'b1, 1'b0, 1'b0);
    run_op("lsr15",  16'hFFFF, 2'b10, 4'd15, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op("pass",   16'h1234, 2'b00, 4'd7,  1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    run_op("amt0",   16'h5A5A, 2'b01, 4'd0,  1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    run_op("glitch", 16'h0F0F, 2'b01, 4'd4,  1'b0, 16'hF0F0, 1'b0, 1'b1, 1'b0);
    run_op("b2b",    16'h8004, 2'b11, 4'd3,  1'b0, 16'hF000, 1'b1, 1'b0, 1'b1);
    run_op("lsr1",   16'h0003, 2'b10, 4'd1,  1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op("asrpos", 16'h4000, 2'b11, 4'd2,  1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("ror1",   16'h0003, 2'b10, 4'd1,  1'b1, 16'h8001, 1'b1, 1'b0, 1'b0);
    run_op("lslrot", 16'h0003, 2'b01, 4'd1,  1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
`else
    run_op("lsrrot", 16'h0003, 2'b10, 4'd1,  1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
